// File: rtl/mem_resp_4c.sv
// Word-addressed 16-bit storage with a fixed-latency, fully pipelined read return
// path and saturating read/write request counters.
module mem_resp_4c #(
  parameter int ADDR_W  = 16,
  parameter int LAT     = 4,
  parameter int WORDS_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << WORDS_W;

  logic [15:0]        mem_q [DEPTH];
  logic [WORDS_W-1:0] word_idx;
  logic               acc_rd;
  logic               acc_wr;
  logic [LAT:0]       vld_q;
  logic [LAT:0]       vld_d;
  logic [15:0]        data_q [LAT+1];
  logic [15:0]        data_d [LAT+1];
  logic [15:0]        rd_count_q;
  logic [15:0]        rd_count_d;
  logic [15:0]        wr_count_q;
  logic [15:0]        wr_count_d;
  logic               addr_unused;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Bit 0 and bits above WORDS_W do not select storage; higher bits alias.
  assign addr_unused = ^addr;

  always_comb begin
    word_idx   = addr[WORDS_W:1];
    acc_rd     = enable & ~wr & ~rst;
    acc_wr     = enable & wr & ~rst;
    rd_count_d = sat_inc(rd_count_q, acc_rd);
    wr_count_d = sat_inc(wr_count_q, acc_wr);
  end

  // Stage 0 captures the stored word at the accept edge, so later writes
  // cannot disturb a read already in flight; stages 1..LAT only shift.
  always_comb begin
    vld_d     = {vld_q[LAT-1:0], acc_rd};
    data_d[0] = mem_q[word_idx];
    for (int k = 1; k <= LAT; k++) begin
      data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem_q[word_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k <= LAT; k++) begin
      data_q[k] <= data_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      rd_count_q <= 16'h0000;
      wr_count_q <= 16'h0000;
    end else begin
      vld_q      <= vld_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign data_valid = vld_q[LAT];
  assign data_out   = vld_q[LAT] ? data_q[LAT] : 16'h0000;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_mem_resp_4c.sv
// Directed bench for mem_resp_4c: latency, ordering, hazard, reset and counter behaviour.
module tb_mem_resp_4c;

  localparam int ADDR_W = 17;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              data_valid;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  int checks;
  int failures;

  mem_resp_4c #(.ADDR_W(ADDR_W), .LAT(4), .WORDS_W(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    tick();
  endtask

  task automatic idle;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = 16'h0000;
  endtask

  task automatic read_check(input logic [ADDR_W-1:0] a, input logic [15:0] exp,
                            input string name);
    drive(1'b1, 1'b0, a, 16'h0000);
    idle();
    tick(); tick(); tick();
    checks++;
    if (data_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: data_valid=%b required 0", name, data_valid);
    end
    tick();
    checks++;
    if ({data_valid, data_out} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL %s: valid=%b data=%h required valid=1 data=%h",
               name, data_valid, data_out, exp);
    end
    tick();
    checks++;
    if ({data_valid, data_out} !== 17'h0) begin
      failures++;
      $display("FAIL %s_after: valid=%b data=%h required 0/0000", name, data_valid, data_out);
    end
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (data_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b required 0", data_valid);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      failures++; $display("FAIL reset_data: got %h required 0000", data_out);
    end
    checks++;
    if (rd_count !== 16'h0000) begin
      failures++; $display("FAIL reset_rd_count: got %h required 0000", rd_count);
    end
    checks++;
    if (wr_count !== 16'h0000) begin
      failures++; $display("FAIL reset_wr_count: got %h required 0000", wr_count);
    end
  endtask

  task automatic test_latency;
    logic [16:0] exp;
    drive(1'b1, 1'b1, 17'h00010, 16'hBEEF);
    drive(1'b1, 1'b0, 17'h00010, 16'h0000);
    idle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      exp = (k == 4) ? {1'b1, 16'hBEEF} : 17'h0;
      checks++;
      if ({data_valid, data_out} !== exp) begin
        failures++;
        $display("FAIL latency_k%0d: valid=%b data=%h required valid=%b data=%h",
                 k, data_valid, data_out, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [4];
    logic [16:0] exp;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 17'(2 * i), vals[i]);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 17'(2 * i), 16'h0000);
    idle();
    checks++;
    if (data_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_pre: valid=%b required 0", data_valid);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      exp = (j < 4) ? {1'b1, vals[j]} : 17'h0;
      checks++;
      if ({data_valid, data_out} !== exp) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%b data=%h required valid=%b data=%h",
                 j, data_valid, data_out, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_shadow_write;
    drive(1'b1, 1'b1, 17'h00020, 16'h00AA);
    drive(1'b1, 1'b0, 17'h00020, 16'h0000);
    drive(1'b1, 1'b1, 17'h00020, 16'h5555);
    idle();
    tick(); tick(); tick();
    checks++;
    if ({data_valid, data_out} !== {1'b1, 16'h00AA}) begin
      failures++;
      $display("FAIL shadow_old: valid=%b data=%h required valid=1 data=00aa",
               data_valid, data_out);
    end
    tick();
    read_check(17'h00020, 16'h5555, "shadow_new");
  endtask

  task automatic test_reset_flight;
    drive(1'b1, 1'b1, 17'h00040, 16'h7777);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 17'h00040, 16'h0000);
    drive(1'b1, 1'b0, 17'h00040, 16'h0000);
    idle();
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 17'h00040, 16'hDEAD);
    rst = 1'b0;
    idle();
    checks++;
    if ({rd_count, wr_count} !== 32'h0) begin
      failures++;
      $display("FAIL flush_counters: rd=%h wr=%h required 0000/0000", rd_count, wr_count);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({data_valid, data_out} !== 17'h0) begin
        failures++;
        $display("FAIL flush_k%0d: valid=%b data=%h required 0/0000", k, data_valid, data_out);
      end
      tick();
    end
    read_check(17'h00040, 16'h7777, "flush_storage");
    checks++;
    if ({rd_count, wr_count} !== {16'h0001, 16'h0000}) begin
      failures++;
      $display("FAIL flush_counts_after: rd=%h wr=%h required 0001/0000", rd_count, wr_count);
    end
  endtask

  task automatic test_alias;
    drive(1'b1, 1'b1, 17'h00012, 16'hA5C3);
    idle();
    read_check(17'h00013, 16'hA5C3, "alias_bit0");
    read_check(17'h10012, 16'hA5C3, "alias_high");
    drive(1'b1, 1'b1, 17'h10014, 16'h1234);
    idle();
    read_check(17'h00014, 16'h1234, "alias_write");
  endtask

  task automatic test_counters;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 17'h00100, 16'h0001);
    drive(1'b1, 1'b0, 17'h00100, 16'h0000);
    drive(1'b0, 1'b1, 17'h00100, 16'h0002);
    drive(1'b1, 1'b1, 17'h00102, 16'h0003);
    drive(1'b1, 1'b0, 17'h00102, 16'h0000);
    drive(1'b1, 1'b0, 17'h00100, 16'h0000);
    idle();
    checks++;
    if ({rd_count, wr_count} !== {16'h0003, 16'h0002}) begin
      failures++;
      $display("FAIL count_mix: rd=%h wr=%h required 0003/0002", rd_count, wr_count);
    end
  endtask

  task automatic test_saturation;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b1;
    wr     = 1'b0;
    addr   = 17'h00100;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (rd_count !== 16'hFFFE) begin
      failures++; $display("FAIL sat_pre: rd_count=%h required fffe", rd_count);
    end
    for (int i = 0; i < 6; i++) tick();
    idle();
    tick();
    checks++;
    if (rd_count !== 16'hFFFF) begin
      failures++; $display("FAIL sat_rd: rd_count=%h required ffff", rd_count);
    end
    checks++;
    if (wr_count !== 16'h0000) begin
      failures++; $display("FAIL sat_wr: wr_count=%h required 0000", wr_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_latency();
    tick(); tick(); tick(); tick();
    test_back_to_back();
    test_shadow_write();
    test_reset_flight();
    test_alias();
    test_counters();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
